// File: rtl/ram_arbiter.sv
// Single-port SRAM front end: arbitrates IF fetches and MEM loads/stores onto one
// req/done sequencer handshake, with a watchdog that aborts hung transactions.
//
// state | meaning
// IDLE  | arbitrate; MEM beats IF, write beats read
// BUSY  | ram_req held, waiting for ram_done or watchdog expiry
// DONE  | owner's ready pulse visible; watchdog cleared
module ram_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_mem_q, owner_mem_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic              err_q, err_d;
    logic [7:0]        wdog_q, wdog_d;

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        err_d       = err_q;
        wdog_d      = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (mem_rd || mem_wr) begin
                    owner_mem_d = 1'b1;
                    ram_we_d    = mem_wr;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    ram_req_d   = 1'b1;
                    state_d     = S_BUSY;
                end else if (if_req) begin
                    owner_mem_d = 1'b0;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_req_d   = 1'b1;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                wdog_d = wdog_q + 8'd1;
                // A done coinciding with expiry wins over the abort.
                if (ram_done) begin
                    ram_req_d = 1'b0;
                    if (!ram_we_q) begin
                        if (owner_mem_q) mem_rdata_d = ram_rdata;
                        else             if_rdata_d  = ram_rdata;
                    end
                    mem_ready_d = owner_mem_q;
                    if_ready_d  = !owner_mem_q;
                    state_d     = S_DONE;
                end else if (wdog_q == WD_LAST) begin
                    ram_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (owner_mem_q) mem_rdata_d = '0;
                    else             if_rdata_d  = '0;
                    mem_ready_d = owner_mem_q;
                    if_ready_d  = !owner_mem_q;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                wdog_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_mem_q <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end

    // Drops in the ready cycle so the pipeline advances exactly once.
    assign stall = ((mem_rd | mem_wr) & ~mem_ready_q) | (if_req & ~if_ready_q);

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_ready = mem_ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural sequencer answers ram_req after a set delay,
// and expected ready/rdata pairs are queued at request time and popped on ready.
module tb_ram_arbiter;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_rd = 1'b0;
    logic              mem_wr = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall;
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = 16'hDEAD;
    logic              ram_done;

    logic              err;

    logic seq_done = 1'b0;
    logic spur_done = 1'b0;
    assign ram_done = seq_done | spur_done;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_done(ram_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_mem;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Sequencer model
    bit                seq_en = 1'b1;
    int                seq_delay = 2;
    int                seq_cnt = 0;
    bit                seq_unstable = 1'b0;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    function automatic logic [15:0] ram_word(input logic [17:0] a);
        return (a == 18'h00123) ? 16'hBEEF : (a[15:0] ^ 16'hC3C3);
    endfunction

    always @(negedge clk) begin
        if (seq_done) begin
            seq_done  = 1'b0;
            seq_cnt   = 0;
            ram_rdata = 16'hDEAD;
        end else if (ram_req === 1'b1) begin
            if (seq_cnt == 0) begin
                cap_we = ram_we; cap_addr = ram_addr; cap_wdata = ram_wdata;
            end else if (ram_we !== cap_we || ram_addr !== cap_addr || ram_wdata !== cap_wdata) begin
                seq_unstable = 1'b1;
            end
            seq_cnt++;
            if (seq_en && (seq_cnt + 1 == seq_delay)) begin
                seq_done  = 1'b1;
                ram_rdata = ram_word(cap_addr);
            end
        end else begin
            seq_cnt = 0;
        end
    end

    // Called at a negedge; counts that negedge as 1. Returns cyc=-1 if no ready within max.
    task automatic wait_ready(input int max, output int cyc, output int nreq, output bit stall_ok);
        cyc = -1; nreq = 0; stall_ok = 1'b1;
        for (int i = 1; i <= max; i++) begin
            if (i > 1) @(negedge clk);
            if (ram_req === 1'b1) nreq++;
            if (if_ready === 1'b1 || mem_ready === 1'b1) begin
                cyc = i;
                return;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ram_req, ram_we, if_ready, mem_ready, err} !== 5'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_hold: req=%b we=%b ifr=%b memr=%b err=%b addr=%h wdata=%h, want all 0",
                     ram_req, ram_we, if_ready, mem_ready, err, ram_addr, ram_wdata);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ram_req, ram_we, if_ready, mem_ready, err, stall} !== 6'b0 || if_rdata !== '0 || mem_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_release: req=%b we=%b ifr=%b memr=%b err=%b stall=%b ifd=%h memd=%h, want all 0",
                     ram_req, ram_we, if_ready, mem_ready, err, stall, if_rdata, mem_rdata);
        end
    endtask

    task automatic test_load();
        int cyc, nreq; bit sok; exp_t e;
        seq_en = 1'b1; seq_delay = 4; seq_unstable = 1'b0;
        mem_rd = 1'b1; mem_addr = 18'h00123;
        sb.push_back({1'b1, 16'hBEEF});
        @(negedge clk);
        n_cmp++;
        if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 18'h00123) begin
            n_err++;
            $display("FAIL load_issue: req=%b we=%b addr=%h, want 1 0 00123", ram_req, ram_we, ram_addr);
        end
        wait_ready(20, cyc, nreq, sok);
        n_cmp++;
        if (cyc !== 4 || nreq !== 3) begin
            n_err++;
            $display("FAIL load_latency: ready at %0d req cycles %0d, want 4 and 3", cyc, nreq);
        end
        n_cmp++;
        if (!sok || stall !== 1'b0) begin
            n_err++;
            $display("FAIL load_stall: held=%b at_ready=%b, want 1 and 0", sok, stall);
        end
        e = sb.pop_front();
        n_cmp++;
        if (mem_ready !== 1'b1 || if_ready !== 1'b0 || mem_rdata !== e.data || seq_unstable) begin
            n_err++;
            $display("FAIL load_data: memr=%b ifr=%b data=%h unstable=%b, want 1 0 %h 0",
                     mem_ready, if_ready, mem_rdata, seq_unstable, e.data);
        end
        mem_rd = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_ready !== 1'b0 || ram_req !== 1'b0) begin
            n_err++;
            $display("FAIL load_pulse: memr=%b req=%b after ready, want 0 0", mem_ready, ram_req);
        end
    endtask

    task automatic test_store(input logic both, input logic [17:0] a, input logic [15:0] wd, input int d);
        int cyc, nreq; bit sok; exp_t e;
        seq_en = 1'b1; seq_delay = d; seq_unstable = 1'b0;
        mem_wr = 1'b1; mem_rd = both; mem_addr = a; mem_wdata = wd;
        sb.push_back({1'b1, mem_rdata});
        @(negedge clk);
        n_cmp++;
        if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== a || ram_wdata !== wd) begin
            n_err++;
            $display("FAIL store_issue(both=%b): req=%b we=%b addr=%h wdata=%h, want 1 1 %h %h",
                     both, ram_req, ram_we, ram_addr, ram_wdata, a, wd);
        end
        wait_ready(20, cyc, nreq, sok);
        n_cmp++;
        if (cyc !== d || !sok || seq_unstable) begin
            n_err++;
            $display("FAIL store_latency(both=%b): ready at %0d stall_ok=%b unstable=%b, want %0d 1 0",
                     both, cyc, sok, seq_unstable, d);
        end
        e = sb.pop_front();
        n_cmp++;
        if (mem_ready !== 1'b1 || if_ready !== 1'b0 || mem_rdata !== e.data) begin
            n_err++;
            $display("FAIL store_rdata(both=%b): memr=%b ifr=%b data=%h, want 1 0 %h",
                     both, mem_ready, if_ready, mem_rdata, e.data);
        end
        mem_wr = 1'b0; mem_rd = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL store_pulse: memr=%b after ready, want 0", mem_ready);
        end
    endtask

    task automatic test_contention();
        int cyc, nreq; bit sok; exp_t e;
        seq_en = 1'b1; seq_delay = 2; seq_unstable = 1'b0;
        if_req = 1'b1; if_addr = 18'h00010;
        mem_rd = 1'b1; mem_addr = 18'h00200;
        sb.push_back({1'b1, ram_word(18'h00200)});
        sb.push_back({1'b0, ram_word(18'h00010)});
        @(negedge clk);
        n_cmp++;
        if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 18'h00200) begin
            n_err++;
            $display("FAIL cont_mem_first: req=%b we=%b addr=%h, want 1 0 00200", ram_req, ram_we, ram_addr);
        end
        wait_ready(20, cyc, nreq, sok);
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== 2 || mem_ready !== 1'b1 || if_ready !== 1'b0 || mem_rdata !== e.data) begin
            n_err++;
            $display("FAIL cont_mem_done: at=%0d memr=%b ifr=%b data=%h, want 2 1 0 %h",
                     cyc, mem_ready, if_ready, mem_rdata, e.data);
        end
        mem_rd = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ram_req !== 1'b0 || if_ready !== 1'b0 || stall !== 1'b1) begin
            n_err++;
            $display("FAIL cont_bubble: req=%b ifr=%b stall=%b, want 0 0 1", ram_req, if_ready, stall);
        end
        @(negedge clk);
        n_cmp++;
        if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 18'h00010) begin
            n_err++;
            $display("FAIL cont_if_issue: req=%b we=%b addr=%h, want 1 0 00010", ram_req, ram_we, ram_addr);
        end
        wait_ready(20, cyc, nreq, sok);
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== 2 || if_ready !== 1'b1 || mem_ready !== 1'b0 || if_rdata !== e.data || stall !== 1'b0) begin
            n_err++;
            $display("FAIL cont_if_done: at=%0d ifr=%b memr=%b data=%h stall=%b, want 2 1 0 %h 0",
                     cyc, if_ready, mem_ready, if_rdata, stall, e.data);
        end
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_ready !== 1'b0 || mem_rdata !== ram_word(18'h00200)) begin
            n_err++;
            $display("FAIL cont_pulse: ifr=%b memd=%h, want 0 %h", if_ready, mem_rdata, ram_word(18'h00200));
        end
    endtask

    task automatic test_spurious();
        int cyc, nreq; bit sok, bad; exp_t e;
        logic [15:0] mem_prev, if_prev;
        mem_prev = mem_rdata; if_prev = if_rdata; bad = 1'b0;
        spur_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spur_done = 1'b0;
            if (if_ready !== 1'b0 || mem_ready !== 1'b0 || ram_req !== 1'b0 ||
                mem_rdata !== mem_prev || if_rdata !== if_prev) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL spurious_done: ifr=%b memr=%b req=%b memd=%h ifd=%h, want 0 0 0 %h %h",
                     if_ready, mem_ready, ram_req, mem_rdata, if_rdata, mem_prev, if_prev);
        end
        seq_en = 1'b1; seq_delay = 2;
        if_req = 1'b1; if_addr = 18'h000AB;
        sb.push_back({1'b0, ram_word(18'h000AB)});
        @(negedge clk);
        wait_ready(20, cyc, nreq, sok);
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== 2 || nreq !== 1 || if_ready !== 1'b1 || if_rdata !== e.data) begin
            n_err++;
            $display("FAIL spurious_follow: at=%0d reqs=%0d ifr=%b data=%h, want 2 1 1 %h",
                     cyc, nreq, if_ready, if_rdata, e.data);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc, nreq; bit sok, bad; exp_t e;
        seq_en = 1'b0;
        mem_rd = 1'b1; mem_addr = 18'h00300;
        sb.push_back({1'b1, 16'h0000});
        @(negedge clk);
        wait_ready(40, cyc, nreq, sok);
        n_cmp++;
        if (cyc !== 16 || nreq !== 15 || !sok) begin
            n_err++;
            $display("FAIL timeout_len: ready at %0d req cycles %0d stall_ok=%b, want 16 15 1", cyc, nreq, sok);
        end
        e = sb.pop_front();
        n_cmp++;
        if (mem_ready !== 1'b1 || mem_rdata !== e.data || err !== 1'b1 || ram_req !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_abort: memr=%b data=%h err=%b req=%b, want 1 %h 1 0",
                     mem_ready, mem_rdata, err, ram_req, e.data);
        end
        mem_rd = 1'b0; bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (err !== 1'b1 || mem_ready !== 1'b0 || ram_req !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL timeout_sticky: err=%b memr=%b req=%b, want 1 0 0", err, mem_ready, ram_req);
        end
    endtask

    task automatic test_async_reset();
        seq_en = 1'b0;
        mem_rd = 1'b1; mem_addr = 18'h00005;
        @(negedge clk);
        n_cmp++;
        if (ram_req !== 1'b1) begin
            n_err++;
            $display("FAIL areset_busy: req=%b, want 1", ram_req);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (ram_req !== 1'b0 || err !== 1'b0 || ram_addr !== '0 || mem_rdata !== '0 || if_rdata !== '0) begin
            n_err++;
            $display("FAIL areset_async: req=%b err=%b addr=%h memd=%h ifd=%h, want 0 0 0 0 0",
                     ram_req, err, ram_addr, mem_rdata, if_rdata);
        end
        mem_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ram_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL areset_after: req=%b stall=%b err=%b memr=%b, want 0 0 0 0",
                     ram_req, stall, err, mem_ready);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store(1'b0, 18'h00040, 16'h5A5A, 3);
        test_store(1'b1, 18'h00041, 16'h1234, 2);
        test_contention();
        test_spurious();
        test_timeout();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
